// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//
// Tracks the destination registers of in-flight multi-cycle operations and
// raises a decode-stage stall when an issuing instruction reads or
// overwrites a register that is still pending.
//
// Each register has a busy bit and a latency countdown. An accepted
// instruction marks its destination busy with a count of issue_lat_i.
// A non-zero count releases the register on its own. A zero count means
// the latency is unknown, and the register stays busy until a matching
// writeback arrives.
//
// Ports
//   clk_i            system clock, all state updates on the rising edge
//   rst_i            synchronous, active-high reset
//   issue_valid_i    decode presents an instruction this cycle
//   issue_regwrite_i the instruction writes issue_rd_i
//   issue_rd_i       destination register index
//   issue_lat_i      cycles until the result is forwardable (0 = unknown)
//   ra_i/rb_i/rc_i   source register indices
//   use_a_i/_b_i/_c_i  the corresponding source is actually read
//   flush_i          branch-taken flush; kills the instruction in decode
//   wb_valid_i       writeback of an unknown-latency result
//   wb_rd_i          register being written back
//   stall_o          hold fetch/decode, insert a bubble into EX
//   busy_mask_o      registered per-register busy bits
//   pending_count_o  number of busy registers
//
// Issue handshake: issue_valid_i is the valid and ~stall_o is the ready.
// An instruction is taken on the rising edge where issue_valid_i is high,
// stall_o is low and flush_i is low. While stall_o is high, decode
// re-presents the same instruction with identical fields; the scoreboard
// keeps no copy of it. flush_i discards the instruction without taking it.

module reg_scoreboard #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int CW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic             issue_regwrite_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic [CW-1:0]    issue_lat_i,
    input  logic [AW-1:0]    ra_i,
    input  logic [AW-1:0]    rb_i,
    input  logic [AW-1:0]    rc_i,
    input  logic             use_a_i,
    input  logic             use_b_i,
    input  logic             use_c_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [AW-1:0]    wb_rd_i,
    output logic             stall_o,
    output logic [NREGS-1:0] busy_mask_o,
    output logic [AW:0]      pending_count_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q [NREGS];
    logic [CW-1:0]    cnt_d [NREGS];

    logic hazard;
    logic accept;

    // Hazard detection looks only at registered busy bits. A writeback or
    // an expiring count in this same cycle does not unblock the instruction
    // until the next cycle.
    always_comb begin
        hazard = (use_a_i & busy_q[ra_i])
               | (use_b_i & busy_q[rb_i])
               | (use_c_i & busy_q[rc_i])
               | (issue_regwrite_i & busy_q[issue_rd_i]);
        stall_o = ~rst_i & issue_valid_i & ~flush_i & hazard;
        accept  = issue_valid_i & issue_regwrite_i & ~stall_o & ~flush_i;
    end

    // Per-register next state. Priority: accept > writeback > countdown.
    // A writeback to a register that is not busy is ignored.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (issue_rd_i == AW'(i))) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = issue_lat_i;
            end else if (wb_valid_i && (wb_rd_i == AW'(i)) && busy_q[i]) begin
                busy_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end else if (busy_q[i] && (cnt_q[i] != '0)) begin
                if (cnt_q[i] == CW'(1)) begin
                    busy_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Reset clears every entry and overrides any accept or writeback
    // presented on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pending_count_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            pending_count_o = pending_count_o + {{AW{1'b0}}, busy_q[i]};
        end
    end

    assign busy_mask_o = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard.
//
// Each record in the table is one clock cycle. It holds the inputs to drive
// in that cycle and the stall_o / busy_mask_o / pending_count_o values
// expected before the next rising edge. The multi-cycle corner cases are
// written out by hand as short sequences below the table.

module tb_reg_scoreboard;

    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic        r;
        logic        iv;
        logic        rw;
        logic [3:0]  rd;
        logic [3:0]  lat;
        logic [3:0]  ra;
        logic        ua;
        logic [3:0]  rb;
        logic        ub;
        logic [3:0]  rc;
        logic        uc;
        logic        fl;
        logic        wbv;
        logic [3:0]  wbrd;
        logic        es;
        logic [15:0] em;
        logic [4:0]  ep;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             issue_valid;
    logic             issue_regwrite;
    logic [AW-1:0]    issue_rd;
    logic [CW-1:0]    issue_lat;
    logic [AW-1:0]    ra, rb, rc;
    logic             use_a, use_b, use_c;
    logic             flush;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             stall;
    logic [NREGS-1:0] busy_mask;
    logic [AW:0]      pending_count;

    reg_scoreboard #(.NREGS(NREGS), .AW(AW), .CW(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .issue_valid_i    (issue_valid),
        .issue_regwrite_i (issue_regwrite),
        .issue_rd_i       (issue_rd),
        .issue_lat_i      (issue_lat),
        .ra_i             (ra),
        .rb_i             (rb),
        .rc_i             (rc),
        .use_a_i          (use_a),
        .use_b_i          (use_b),
        .use_c_i          (use_c),
        .flush_i          (flush),
        .wb_valid_i       (wb_valid),
        .wb_rd_i          (wb_rd),
        .stall_o          (stall),
        .busy_mask_o      (busy_mask),
        .pending_count_o  (pending_count)
    );

    // scoreboard
    logic [21:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, iv, rw, input logic [3:0] rd, lat,
        input logic [3:0] ra_v, input logic ua,
        input logic [3:0] rb_v, input logic ub,
        input logic [3:0] rc_v, input logic uc,
        input logic fl, wbv, input logic [3:0] wbrd,
        input logic es, input logic [15:0] em, input logic [4:0] ep);
        vec_t v;
        v.r = r; v.iv = iv; v.rw = rw; v.rd = rd; v.lat = lat;
        v.ra = ra_v; v.ua = ua; v.rb = rb_v; v.ub = ub; v.rc = rc_v; v.uc = uc;
        v.fl = fl; v.wbv = wbv; v.wbrd = wbrd;
        v.es = es; v.em = em; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs, check mid-cycle, advance past the edge
    task automatic apply(input vec_t v);
        logic [21:0] e;
        rst            = v.r;
        issue_valid    = v.iv;
        issue_regwrite = v.rw;
        issue_rd       = v.rd;
        issue_lat      = v.rw ? v.lat : 4'($urandom_range(0, 15));
        ra             = v.ra;
        use_a          = v.ua;
        rb             = v.rb;
        use_b          = v.ub;
        rc             = v.uc ? v.rc : 4'($urandom_range(0, 15));
        use_c          = v.uc;
        flush          = v.fl;
        wb_valid       = v.wbv;
        wb_rd          = v.wbrd;
        exp_q.push_back({v.es, v.em, v.ep});
        @(negedge clk);
        e = exp_q.pop_front();
        check("stall", {31'd0, stall}, {31'd0, e[21]});
        check("busy_mask", {16'd0, busy_mask}, {16'd0, e[20:5]});
        check("pending_count", {27'd0, pending_count}, {27'd0, e[4:0]});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // columns: r iv rw rd lat | ra ua rb ub rc uc | fl wbv wbrd | stall mask count
        // reset held with an issue pending, then first cycle after reset
        vecs.push_back(mk(1,1,1, 3,2,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(mk(1,1,1, 3,2,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        // fixed latency 3 on r5, dependent on ra
        vecs.push_back(mk(0,1,1, 5,3,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(mk(0,1,0, 0,0,  5,1, 0,0, 0,0, 0,0,0, 1,16'h0020,1));
        vecs.push_back(mk(0,1,0, 0,0,  5,1, 0,0, 0,0, 0,0,0, 1,16'h0020,1));
        vecs.push_back(mk(0,1,0, 0,0,  5,1, 0,0, 0,0, 0,0,0, 1,16'h0020,1));
        vecs.push_back(mk(0,1,0, 0,0,  5,1, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        // WAW on r4 while r7 is busy too
        vecs.push_back(mk(0,1,1, 4,5,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(mk(0,1,1, 7,2,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0010,1));
        vecs.push_back(mk(0,1,1, 4,1,  0,0, 0,0, 0,0, 0,0,0, 1,16'h0090,2));
        vecs.push_back(mk(0,1,1, 4,1,  0,0, 0,0, 0,0, 0,0,0, 1,16'h0090,2));
        vecs.push_back(mk(0,1,1, 4,1,  0,0, 0,0, 0,0, 0,0,0, 1,16'h0010,1));
        vecs.push_back(mk(0,1,1, 4,1,  0,0, 0,0, 0,0, 0,0,0, 1,16'h0010,1));
        vecs.push_back(mk(0,1,1, 4,1,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        // new r4 entry lasts one cycle; unused ra does not stall, used rb does
        vecs.push_back(mk(0,1,0, 0,0,  4,0, 4,1, 0,0, 0,0,0, 1,16'h0010,1));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        // flush: hazard masked, no entry for r10, r6 still expires on time
        vecs.push_back(mk(0,1,1, 6,2,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        vecs.push_back(mk(0,1,1,10,3,  6,1, 0,0, 0,0, 1,0,0, 0,16'h0040,1));
        vecs.push_back(mk(0,1,0, 0,0,  0,0, 0,0, 6,1, 0,0,0, 1,16'h0040,1));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        // accept beats writeback to the same register
        vecs.push_back(mk(0,1,1, 9,2,  0,0, 0,0, 0,0, 0,1,9, 0,16'h0000,0));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0200,1));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0200,1));
        vecs.push_back(mk(0,0,0, 0,0,  0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));

        rst = 1'b1; issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = '0;
        issue_lat = '0; ra = '0; rb = '0; rc = '0; use_a = 1'b0; use_b = 1'b0;
        use_c = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k]);
        end

        // unknown latency on r2: stalls until writeback, a stray writeback
        // to another register does nothing
        apply(mk(0,1,1, 2,0, 0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        for (int j = 0; j < 20; j++) begin
            apply(mk(0,1,0, 0,0, 0,0, 2,1, 0,0, 0,(j == 10),5, 1,16'h0004,1));
        end
        apply(mk(0,1,0, 0,0, 0,0, 2,1, 0,0, 0,1,2, 1,16'h0004,1));
        apply(mk(0,1,0, 0,0, 0,0, 2,1, 0,0, 0,0,0, 0,16'h0000,0));

        // reset with three registers busy (r0 included), while an accept
        // and a writeback are also presented
        apply(mk(0,1,1, 0,0, 0,0, 0,0, 0,0, 0,0,0, 0,16'h0000,0));
        apply(mk(0,1,1, 8,7, 0,0, 0,0, 0,0, 0,0,0, 0,16'h0001,1));
        apply(mk(0,1,1,15,0, 0,0, 0,0, 0,0, 0,0,0, 0,16'h0101,2));
        apply(mk(1,1,1,12,3, 8,1, 0,0, 0,0, 0,1,0, 0,16'h8101,3));
        apply(mk(0,1,0, 0,0, 8,1,15,1, 0,0, 0,0,0, 0,16'h0000,0));

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
